// File: rtl/mem_access_arbiter_if.sv
// Requester and RAM pin bundle for mem_access_arbiter.
// slave = arbiter side; master = requesters plus the RAM that answers mem_rdata.
interface mem_access_arbiter_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              done0;
   logic              done1;
   logic [DATA_W-1:0] rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_rdata,
      output gnt0, gnt1, done0, done1, rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_rdata,
      input  gnt0, gnt1, done0, done1, rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a single-port RAM with 1-cycle read latency.
// Outputs decode only from registered state, so requester inputs never glitch the RAM pins.
module mem_access_arbiter #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   mem_access_arbiter_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ACCESS  = 2'b01,
      RD_WAIT = 2'b10,
      DONE    = 2'b11
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic              sel_reg;
   logic              we_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic              last_grant_reg;
   logic [DATA_W-1:0] rdata_reg;

   logic              any_req;
   logic              pick;

   // On a tie the requester that did not win last time is chosen.
   assign any_req = bus.req0 | bus.req1;
   assign pick    = (bus.req0 && bus.req1) ? ~last_grant_reg : bus.req1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (any_req) state_next = ACCESS;
         ACCESS:  state_next = we_reg ? DONE : RD_WAIT;
         RD_WAIT: state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_reg        <= 1'b0;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         last_grant_reg <= 1'b1;
         rdata_reg      <= '0;
      end else begin
         if (state_reg == IDLE && any_req) begin
            sel_reg        <= pick;
            we_reg         <= pick ? bus.we1    : bus.we0;
            addr_reg       <= pick ? bus.addr1  : bus.addr0;
            wdata_reg      <= pick ? bus.wdata1 : bus.wdata0;
            last_grant_reg <= pick;
         end
         // The RAM presents read data during the cycle after the access.
         if (state_reg == RD_WAIT) begin
            rdata_reg <= bus.mem_rdata;
         end
      end
   end

   logic busy;
   assign busy = (state_reg != IDLE);

   assign bus.gnt0      = busy && !sel_reg;
   assign bus.gnt1      = busy &&  sel_reg;
   assign bus.done0     = (state_reg == DONE) && !sel_reg;
   assign bus.done1     = (state_reg == DONE) &&  sel_reg;
   assign bus.rdata     = rdata_reg;
   assign bus.mem_en    = (state_reg == ACCESS);
   assign bus.mem_we    = (state_reg == ACCESS) && we_reg;
   assign bus.mem_addr  = (state_reg == ACCESS) ? addr_reg  : '0;
   assign bus.mem_wdata = (state_reg == ACCESS) ? wdata_reg : '0;

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for one single-port synchronous RAM (1-cycle read latency) in the memory integration subsystem.
- Accepts one read or write command at a time and drives the RAM control, address and write-data pins.
- Returns read data and a one-cycle completion pulse to the requester that was granted.
- Core is a 2-bit encoded FSM held in an asynchronously reset state register.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- req0  input  1  requester 0 command request (level)
- we0  input  1  requester 0: 1 = write, 0 = read
- addr0  input  ADDR_W  requester 0 address
- wdata0  input  DATA_W  requester 0 write data
- req1  input  1  requester 1 command request (level)
- we1  input  1  requester 1: 1 = write, 0 = read
- addr1  input  ADDR_W  requester 1 address
- wdata1  input  DATA_W  requester 1 write data
- gnt0  output  1  requester 0 owns the RAM
- gnt1  output  1  requester 1 owns the RAM
- done0  output  1  one-cycle completion pulse, requester 0
- done1  output  1  one-cycle completion pulse, requester 1
- rdata  output  DATA_W  read result, valid while done0/done1 is high after a read
- mem_en  output  1  RAM enable
- mem_we  output  1  RAM write enable
- mem_addr  output  ADDR_W  RAM address
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, valid the cycle after a read access

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - Latched command registers and rdata cleared to 0.
  - All outputs 0 immediately, including mem_en and mem_we.
- State encoding: IDLE=2'b00, ACCESS=2'b01, RD_WAIT=2'b10, DONE=2'b11.
- IDLE, arbitration:
  - Only req0 high: select 0. Only req1 high: select 1.
  - Both high: select the requester that is not last_grant.
  - On any selection, on the clock edge: latch sel, we_sel, addr_sel, wdata_sel; set last_grant=sel; go to ACCESS.
  - Neither request high: stay in IDLE.
- ACCESS:
  - mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values.
  - Next state: RD_WAIT if read, DONE if write.
- RD_WAIT:
  - mem_en=0; mem_rdata is captured into rdata at the clock edge.
  - Next state: DONE.
- DONE:
  - done[sel]=1 for exactly this cycle.
  - rdata holds the read value; it is unchanged after a write.
  - Next state: IDLE, always.
- gnt[sel]=1 in ACCESS, RD_WAIT and DONE; gnt0 and gnt1 are never high together; both are 0 in IDLE.
- mem_*, gnt*, done* are decoded combinationally from the registered state and latched registers only. They never depend on the req/cmd inputs, so they are glitch-free with respect to requesters.
- Latency, measured from the IDLE cycle in which the request is sampled:
  - write: done at cycle +2.
  - read: done at cycle +3.
  - Minimum spacing between accesses: 3 cycles for a write, 4 cycles for a read.
- Commands are sampled only in IDLE. Changes to we/addr/wdata during a transaction are ignored.
- A req still high during DONE is treated as a new request in the following IDLE cycle.
- Fairness: if both requests are held continuously, grants alternate 0,1,0,1,...
- rdata is not cleared between transactions; it holds the last read value until the next read completes.
- Reset mid-transaction: the access is aborted, no done pulse is produced, and the FSM returns to IDLE.

Test Plan:
- req0=1, we0=1, addr0=4'h3, wdata0=8'hA5, held one cycle in IDLE -> mem_en=mem_we=1, mem_addr=3, mem_wdata=A5 next cycle; done0 one cycle later; gnt1 stays 0.
- Then req1=1, we1=0, addr1=4'h3 (behavioural RAM model) -> mem_en=1, mem_we=0 at +1; done1 at +3 with rdata=8'hA5.
- req0 and req1 both rise in the same cycle after reset, both writes -> requester 0 served first (done0), then requester 1 (done1 3 cycles later).
- Both requests held high for 6 transactions -> grant order 0,1,0,1,0,1; gnt0&gnt1 never both 1.
- rst driven low during RD_WAIT of a read -> all outputs 0 asynchronously; no done pulse; after release, a new req0 read of address 4'hF completes normally, with mem_addr=4'hF and no wrap.
- Write DATA=8'hFF to address 4'h0, then read it back -> rdata=8'hFF; a following write leaves rdata unchanged.
